// File: rtl/dm_store_mem_pkg.sv
// ============================================================================
// dm_store_mem_pkg : store-mode and store-size codes shared by M/W stages
// Rev 1.0
// ============================================================================
`default_nettype none

package dm_store_mem_pkg;

  localparam logic [1:0] SW_NORM = 2'b00;
  localparam logic [1:0] SW_L    = 2'b01;
  localparam logic [1:0] SW_R    = 2'b10;

  localparam logic [1:0] ST_W    = 2'b00;
  localparam logic [1:0] ST_H    = 2'b01;
  localparam logic [1:0] ST_B    = 2'b10;

  function automatic logic [4:0] byte_shamt(input logic [1:0] nbytes);
    return {nbytes, 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_store_mem_store_align.sv
// ============================================================================
// store_align : byte enables, lane-aligned store data and misalign flag
// Rev 1.0
// ============================================================================
`default_nettype none

module store_align
  import dm_store_mem_pkg::*;
(
  input  logic [1:0]  sw_mode,
  input  logic [1:0]  store_size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_aligned,
  output logic        misalign
);

  logic [1:0] w_off_inv;

  assign w_off_inv = 2'd3 - off;

  always_comb begin
    be            = 4'b0000;
    wdata_aligned = 32'h0;
    misalign      = 1'b0;
    case (sw_mode)
      SW_L: begin
        be            = 4'b1111 >> w_off_inv;
        wdata_aligned = wdata >> byte_shamt(w_off_inv);
      end
      SW_R: begin
        be            = 4'b1111 << off;
        wdata_aligned = wdata << byte_shamt(off);
      end
      SW_NORM: begin
        case (store_size)
          ST_W: begin
            wdata_aligned = wdata;
            if (off == 2'b00) be = 4'b1111;
            else              misalign = 1'b1;
          end
          ST_H: begin
            wdata_aligned = {wdata[15:0], wdata[15:0]};
            if (off[0])      misalign = 1'b1;
            else if (off[1]) be = 4'b1100;
            else             be = 4'b0011;
          end
          ST_B: begin
            wdata_aligned = {4{wdata[7:0]}};
            be            = 4'b0001 << off;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_store_mem.sv
// ============================================================================
// dm_store_mem : M-stage byte-enabled data memory with M/W read latch
// Rev 1.0
// ============================================================================
`default_nettype none

module dm_store_mem
  import dm_store_mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [1:0]  SwMode,
  input  logic [1:0]  StoreSize,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RDataW,
  output logic [1:0]  AddrLowW,
  output logic        AlignErr
);

  logic [31:0]       mem_q [MEM_WORDS];
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_off;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_aligned;
  logic              w_misalign;
  logic [31:0]       word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        addr_low_q, addr_low_d;
  logic              addr_unused;

  // Upper address bits are dropped so the array aliases every 4 KB.
  assign w_idx       = Addr[ADDR_W+1:2];
  assign w_off       = Addr[1:0];
  assign addr_unused = ^Addr[31:ADDR_W+2];

  store_align u_store_align (
    .sw_mode       (SwMode),
    .store_size    (StoreSize),
    .off           (w_off),
    .wdata         (WData),
    .be            (w_be),
    .wdata_aligned (w_wdata_aligned),
    .misalign      (w_misalign)
  );

  assign AlignErr = MemWrite & w_misalign;

  always_comb begin
    word_d = mem_q[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) word_d[8*i +: 8] = w_wdata_aligned[8*i +: 8];
    end
  end

  // Latch reads the pre-write word, so a same-edge store shows up next access.
  always_comb begin
    rdata_d    = mem_q[w_idx];
    addr_low_d = w_off;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= 32'h0;
      rdata_q    <= 32'h0;
      addr_low_q <= 2'b00;
    end else begin
      if (MemWrite) mem_q[w_idx] <= word_d;
      rdata_q    <= rdata_d;
      addr_low_q <= addr_low_d;
    end
  end

  assign RDataW   = rdata_q;
  assign AddrLowW = addr_low_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_store_mem.sv
// ============================================================================
// tb_dm_store_mem : directed self-checking bench for dm_store_mem
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dm_store_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [1:0]  SwMode;
  logic [1:0]  StoreSize;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RDataW;
  logic [1:0]  AddrLowW;
  logic        AlignErr;

  int n_vec = 0;
  int n_err = 0;

  dm_store_mem #(.MEM_WORDS(1024), .ADDR_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .SwMode    (SwMode),
    .StoreSize (StoreSize),
    .Addr      (Addr),
    .WData     (WData),
    .RDataW    (RDataW),
    .AddrLowW  (AddrLowW),
    .AlignErr  (AlignErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] m, input logic [1:0] s);
    @(negedge clk);
    MemWrite = 1'b1; Addr = a; WData = d; SwMode = m; StoreSize = s;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic read(input logic [31:0] a);
    @(negedge clk);
    MemWrite = 1'b0; Addr = a; SwMode = 2'b00; StoreSize = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; SwMode = 2'b00; StoreSize = 2'b00;
    Addr = 32'h0; WData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", RDataW, 32'h0);
    check("reset_addrlow", {30'h0, AddrLowW}, 32'h0);
    @(negedge clk); reset = 1'b0;

    store(32'h10, 32'hDEADBEEF, 2'b00, 2'b00);
    read(32'h10);
    check("sw_read", RDataW, 32'hDEADBEEF);
    check("sw_addrlow", {30'h0, AddrLowW}, 32'h0);

    store(32'h20, 32'h11223344, 2'b00, 2'b00);
    store(32'h21, 32'h000000AB, 2'b00, 2'b10);
    read(32'h20);
    check("sb_off1", RDataW, 32'h1122AB44);
    store(32'h22, 32'h0000CDEF, 2'b00, 2'b01);
    read(32'h23);
    check("sh_off2", RDataW, 32'hCDEFAB44);
    check("addrlow_3", {30'h0, AddrLowW}, 32'h3);

    store(32'h30, 32'h11223344, 2'b00, 2'b00);
    store(32'h30, 32'hAABBCCDD, 2'b01, 2'b00);
    read(32'h30);
    check("swl_off0", RDataW, 32'h112233AA);
    store(32'h34, 32'h11223344, 2'b00, 2'b00);
    store(32'h35, 32'hAABBCCDD, 2'b01, 2'b00);
    read(32'h34);
    check("swl_off1", RDataW, 32'h1122AABB);
    store(32'h38, 32'h11223344, 2'b00, 2'b00);
    store(32'h3B, 32'hAABBCCDD, 2'b01, 2'b00);
    read(32'h38);
    check("swl_off3", RDataW, 32'hAABBCCDD);

    store(32'h50, 32'h11223344, 2'b00, 2'b00);
    store(32'h53, 32'hAABBCCDD, 2'b10, 2'b00);
    read(32'h50);
    check("swr_off3", RDataW, 32'hDD223344);
    store(32'h54, 32'h11223344, 2'b00, 2'b00);
    store(32'h56, 32'hAABBCCDD, 2'b10, 2'b00);
    read(32'h54);
    check("swr_off2", RDataW, 32'hCCDD3344);
    store(32'h58, 32'h11223344, 2'b00, 2'b00);
    store(32'h58, 32'hAABBCCDD, 2'b10, 2'b00);
    read(32'h58);
    check("swr_off0", RDataW, 32'hAABBCCDD);

    store(32'h40, 32'h12345678, 2'b00, 2'b00);
    @(negedge clk);
    MemWrite = 1'b1; Addr = 32'h42; WData = 32'hFFFFFFFF; SwMode = 2'b00; StoreSize = 2'b00;
    #1 check("alignerr_sw", {31'h0, AlignErr}, 32'h1);
    @(posedge clk); #1 MemWrite = 1'b0;
    #1 check("alignerr_idle", {31'h0, AlignErr}, 32'h0);
    read(32'h40);
    check("sw_misalign_nowrite", RDataW, 32'h12345678);
    @(negedge clk);
    MemWrite = 1'b1; Addr = 32'h43; WData = 32'hFFFFFFFF; SwMode = 2'b00; StoreSize = 2'b01;
    #1 check("alignerr_sh", {31'h0, AlignErr}, 32'h1);
    @(posedge clk); #1 MemWrite = 1'b0;
    read(32'h40);
    check("sh_misalign_nowrite", RDataW, 32'h12345678);
    @(negedge clk);
    MemWrite = 1'b1; Addr = 32'h40; WData = 32'hFFFFFFFF; SwMode = 2'b11; StoreSize = 2'b00;
    #1 check("alignerr_reserved", {31'h0, AlignErr}, 32'h0);
    @(posedge clk); #1 MemWrite = 1'b0;
    store(32'h40, 32'hFFFFFFFF, 2'b00, 2'b11);
    read(32'h40);
    check("reserved_nowrite", RDataW, 32'h12345678);

    store(32'h60, 32'h00000001, 2'b00, 2'b00);
    store(32'h60, 32'h00000002, 2'b00, 2'b00);
    check("same_edge_old", RDataW, 32'h00000001);
    read(32'h60);
    check("same_edge_new", RDataW, 32'h00000002);

    store(32'h1004, 32'h00000005, 2'b00, 2'b00);
    read(32'h4);
    check("wrap_read", RDataW, 32'h00000005);
    #2 reset = 1'b1;
    #1 check("async_reset_rdata", RDataW, 32'h0);
    @(negedge clk); reset = 1'b0;
    read(32'h4);
    check("post_reset_word4", RDataW, 32'h0);
    read(32'h10);
    check("post_reset_word10", RDataW, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dm_store_mem.md
Name: dm_store_mem

Overview:
- M-stage data memory for the pipelined MIPS core.
- Sits directly downstream of the M-stage decoder and consumes its MemWrite and SwMode outputs, plus the store size, address and store data from the EX/MEM register.
- Performs byte-enabled stores: sw, sh, sb, swl, swr.
- Latches the addressed word and byte offset into the M/W boundary for W-stage load extraction.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words (4 KB).
- ADDR_W, 10, word-index width; must satisfy 2**ADDR_W == MEM_WORDS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  store enable from the M-stage decoder.
- SwMode  input  2  00 normal store, 01 swl, 10 swr, 11 reserved (no write).
- StoreSize  input  2  00 word, 01 half, 10 byte, 11 reserved (no write); ignored when SwMode != 00.
- Addr  input  32  byte address (ALU result).
- WData  input  32  rt value after forwarding.
- RDataW  output  32  registered word read at Addr, to the W stage.
- AddrLowW  output  2  registered Addr[1:0], to the W stage.
- AlignErr  output  1  combinational; high when MemWrite is set and the store is misaligned.

Behaviour:
- Reset (asynchronous, immediate on assertion): every memory word = 0, RDataW = 0, AddrLowW = 0. Reset held across edges blocks all writes and latches.
- Index: idx = Addr[ADDR_W+1:2]. Higher address bits are ignored, so the array wraps modulo 4 KB. Offset: off = Addr[1:0].
- Byte enables and aligned data (be[i] enables byte i, bits 8i+7:8i), in priority order:
  - swl: be = 0001/0011/0111/1111 for off = 0/1/2/3; data = WData >> 8*(3-off).
  - swr: be = 1111/1110/1100/1000 for off = 0/1/2/3; data = WData << 8*off.
  - sw: be = 1111 only when off = 00; data = WData.
  - sh: be = 0011 (off = 00) or 1100 (off = 10); data = {WData[15:0], WData[15:0]}.
  - sb: be = 1 << off; data = WData[7:0] replicated 4 times.
- Misaligned stores (sw with off != 0, sh with off[0] = 1): be = 0000, AlignErr = 1, memory unchanged.
- Reserved SwMode or StoreSize: be = 0000, AlignErr = 0.
- Write: on a rising edge with MemWrite = 1, each byte with be[i] = 1 is updated; all other bytes are kept. Store latency is 1 cycle.
- M/W latch: every rising edge, RDataW <= mem[idx] and AddrLowW <= off, regardless of MemWrite. This takes no stall or flush; W-stage control gating happens downstream.
- Same-edge store and latch to the same word: RDataW captures the pre-write (old) value. The visible effect appears on the next access.
- MemWrite = 0: be is ignored, AlignErr = 0.
- Reset asserted mid-cycle after a store: the store is lost. Memory reads 0 after reset.

Decomposition:
- Shared package: SwMode codes (SW_NORM = 2'b00, SW_L = 2'b01, SW_R = 2'b10) and StoreSize codes (ST_W = 2'b00, ST_H = 2'b01, ST_B = 2'b10). The M-stage decoder and the W-stage load extractor use the same package.
- One combinational sub-module, store_align. Inputs: SwMode, StoreSize, off, WData. Outputs: be[3:0], wdata_aligned[31:0], misalign.
- The top level holds the array, the byte-write loop and the M/W latch.

Test Plan:
- Reset then sw: reset pulse, then sw Addr = 0x10, WData = 0xDEADBEEF. Next edge, Addr = 0x10 with MemWrite = 0 -> RDataW = 0xDEADBEEF, AddrLowW = 0.
- Byte stores: word 0x20 = 0x11223344. sb Addr = 0x21, WData = 0xAB -> word 0x1122AB44. sh Addr = 0x22, WData = 0xCDEF -> word 0xCDEFAB44.
- swl: word 0x30 = 0x11223344, WData = 0xAABBCCDD. Off 0 -> 0x112233AA. Off 1 (fresh word) -> 0x1122AABB. Off 3 -> 0xAABBCCDD.
- swr: same init and WData. Off 3 -> 0xDD223344. Off 2 -> 0xCCDD3344. Off 0 -> 0xAABBCCDD.
- Misalign: sw Addr = 0x42 -> AlignErr = 1, word 0x40 unchanged. sh Addr = 0x43 -> AlignErr = 1, no write.
- Wrap and async reset: sw Addr = 0x1004, WData = 0x5 -> word at 0x4 = 0x5. Assert reset between edges -> RDataW = 0 immediately, and word 0x4 reads 0 afterward.
